// File: rtl/dm_cache_pkg.sv
// rtl/dm_cache_pkg.sv - shared types for the direct-mapped cache memory-side interface
package dm_cache_pkg;

    localparam int LINE_W_DEF = 128;

    typedef struct packed {
        logic [LINE_W_DEF-1:0] data;
        logic [31:0]           addr;
        logic                  rw;
        logic                  valid;
    } mem_req_t;

    typedef struct packed {
        logic [LINE_W_DEF-1:0] data;
        logic                  ready;
    } mem_res_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } resp_state_t;

endpackage

// File: rtl/dm_line_ram.sv
// rtl/dm_line_ram.sv - single-port DEPTH x LINE_W line RAM, registered read, optional DM_MEM_INIT_PATTERN_EN preload
module dm_line_ram #(
    parameter int LINE_W = 128,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

`ifdef DM_MEM_INIT_PATTERN_EN
    localparam int OFF = $clog2(LINE_W / 8);

    typedef logic [LINE_W-1:0] mem_array_t [DEPTH];

    // Every 32-bit word carries its own byte address, word 0 in the LSBs.
    function automatic mem_array_t init_pattern();
        mem_array_t m;
        for (int i = 0; i < DEPTH; i++) begin
            for (int w = 0; w < LINE_W / 32; w++) begin
                m[i][w*32 +: 32] = 32'h8000_0000 | (32'(i) << OFF) | (32'(w) << 2);
            end
        end
        return m;
    endfunction

    mem_array_t mem = init_pattern();
`else
    logic [LINE_W-1:0] mem [DEPTH];
`endif

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dm_cache_mem_responder.sv
// rtl/dm_cache_mem_responder.sv - fixed-latency backing memory for the cache memory-side port (DM_MEM_INIT_PATTERN_EN selects preload)
module dm_cache_mem_responder
    import dm_cache_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [31:0]       mem_req_addr,
    input  logic [LINE_W-1:0] mem_req_data,
    output logic [LINE_W-1:0] mem_res_data,
    output logic              mem_res_ready,
    output logic              mem_busy
);

    localparam int OFF   = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(DEPTH);

    resp_state_t       state;
    resp_state_t       state_next;
    logic [7:0]        count;
    logic              lat_rw;
    logic [IDX_W-1:0]  lat_idx;
    logic [LINE_W-1:0] lat_data;
    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  ram_addr;
    logic              ram_we;
    logic [LINE_W-1:0] ram_rdata;
    logic              finishing;
    logic              unused_addr_bits;

    assign req_idx          = mem_req_addr[OFF +: IDX_W];
    assign unused_addr_bits = ^{mem_req_addr[31:OFF+IDX_W], mem_req_addr[OFF-1:0]};

    // Last BUSY cycle: the following edge enters RESPOND, N+LATENCY after acceptance.
    assign finishing = (state == BUSY) && (count == 8'd0);

    // In IDLE the RAM already reads the incoming index so LATENCY=1 reads still land in time.
    assign ram_addr = (state == IDLE) ? req_idx : lat_idx;
    assign ram_we   = finishing && lat_rw;

    dm_line_ram #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (lat_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mem_req_valid) state_next = BUSY;
            BUSY:    if (count == 8'd0) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= 8'd0;
            lat_rw       <= 1'b0;
            lat_idx      <= '0;
            lat_data     <= '0;
            mem_res_data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && mem_req_valid) begin
                lat_rw   <= mem_req_rw;
                lat_idx  <= req_idx;
                lat_data <= mem_req_data;
                count    <= 8'(LATENCY - 1);
            end else if (state == BUSY && count != 8'd0) begin
                count <= count - 8'd1;
            end
            if (finishing) begin
                mem_res_data <= lat_rw ? '0 : ram_rdata;
            end
        end
    end

    assign mem_res_ready = (state == RESPOND);
    assign mem_busy      = (state != IDLE);

endmodule
